// File: rtl/rx_iq_scheduler_if.sv
`default_nettype none
// ============================================================================
// rx_iq_scheduler_if
// Sample-side and bus-side signal bundle of the RX I/Q scheduler.
// Revision: 1.0
// ============================================================================
interface rx_iq_scheduler_if #(
  parameter int DEPTH = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic               sample_valid;
  logic signed [15:0] I;
  logic signed [15:0] Q;
  logic               rx_enable;
  logic               pop;
  logic               clear_flags;
  logic signed [15:0] I_out;
  logic signed [15:0] Q_out;
  logic               out_valid;
  logic [LW-1:0]      level;
  logic               data_ready_irq;
  logic [7:0]         overflow_cnt;
  logic               underrun;

  modport master (
    output sample_valid, I, Q, rx_enable, pop, clear_flags,
    input  I_out, Q_out, out_valid, level, data_ready_irq, overflow_cnt, underrun
  );

  modport slave (
    input  sample_valid, I, Q, rx_enable, pop, clear_flags,
    output I_out, Q_out, out_valid, level, data_ready_irq, overflow_cnt, underrun
  );
endinterface
`default_nettype wire

// File: rtl/rx_iq_scheduler.sv
`default_nettype none
// ============================================================================
// rx_iq_scheduler
// DDC I/Q sample FIFO with registered pop port, fill IRQ and error flags.
// Revision: 1.0
// ============================================================================
module rx_iq_scheduler #(
  parameter int DEPTH     = 16,
  parameter int THRESHOLD = 8
) (
  input  wire                  clk_in,
  input  wire                  reset_in,
  rx_iq_scheduler_if.slave     bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] c_depth_lvl = LW'(DEPTH);
  localparam logic [LW-1:0] c_thresh    = LW'(THRESHOLD);

  logic [31:0]        r_mem [DEPTH];
  logic [AW-1:0]      r_wptr;
  logic [AW-1:0]      r_rptr;
  logic [LW-1:0]      r_level;
  logic signed [15:0] r_i_out;
  logic signed [15:0] r_q_out;
  logic               r_out_valid;
  logic               r_irq;
  logic [7:0]         r_ovf_cnt;
  logic               r_underrun;

  logic        w_push_req;
  logic        w_empty;
  logic        w_full;
  logic        w_do_pop;
  logic        w_empty_pop;
  logic        w_do_push;
  logic        w_overflow;
  logic [31:0] w_rd;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
  assign w_push_req  = bus.sample_valid & bus.rx_enable;
  assign w_empty     = (r_level == '0);
  assign w_full      = (r_level == c_depth_lvl);
  assign w_do_pop    = bus.pop & bus.rx_enable & ~w_empty;
  assign w_empty_pop = bus.pop & ~w_do_pop;
  assign w_do_push   = w_push_req & (~w_full | w_do_pop);
  assign w_overflow  = w_push_req & w_full & ~w_do_pop;
  assign w_rd        = r_mem[r_rptr];

  always_ff @(posedge clk_in) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= {bus.I, bus.Q};
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
      r_i_out     <= '0;
      r_q_out     <= '0;
      r_out_valid <= 1'b0;
      r_irq       <= 1'b0;
      r_ovf_cnt   <= '0;
      r_underrun  <= 1'b0;
    end else begin
      r_irq       <= (r_level >= c_thresh);
      r_out_valid <= bus.pop;

      if (w_do_pop) begin
        r_i_out <= w_rd[31:16];
        r_q_out <= w_rd[15:0];
      end else if (w_empty_pop) begin
        r_i_out <= '0;
        r_q_out <= '0;
      end

      if (!bus.rx_enable) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_level <= '0;
      end else begin
        if (w_do_push) r_wptr <= r_wptr + AW'(1);
        if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
        unique case ({w_do_push, w_do_pop})
          2'b10:   r_level <= r_level + LW'(1);
          2'b01:   r_level <= r_level - LW'(1);
          default: r_level <= r_level;
        endcase
      end

      // A clear coincident with a new event leaves that event counted.
      if (bus.clear_flags) begin
        r_ovf_cnt  <= w_overflow ? 8'd1 : 8'd0;
        r_underrun <= w_empty_pop;
      end else begin
        if (w_overflow && r_ovf_cnt != 8'hFF) r_ovf_cnt <= r_ovf_cnt + 8'd1;
        if (w_empty_pop) r_underrun <= 1'b1;
      end
    end
  end

  assign bus.I_out          = r_i_out;
  assign bus.Q_out          = r_q_out;
  assign bus.out_valid      = r_out_valid;
  assign bus.level          = r_level;
  assign bus.data_ready_irq = r_irq;
  assign bus.overflow_cnt   = r_ovf_cnt;
  assign bus.underrun       = r_underrun;
endmodule
`default_nettype wire

// File: tb/tb_rx_iq_scheduler.sv
`default_nettype none
// ============================================================================
// tb_rx_iq_scheduler
// Directed bench for rx_iq_scheduler with a queue-based reference model.
// Revision: 1.0
// ============================================================================
module tb_rx_iq_scheduler;
  localparam int DEPTH     = 16;
  localparam int THRESHOLD = 8;

  logic clk_in   = 1'b0;
  logic reset_in = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  rx_iq_scheduler_if #(.DEPTH(DEPTH)) bus ();

  rx_iq_scheduler #(.DEPTH(DEPTH), .THRESHOLD(THRESHOLD)) dut (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .bus      (bus)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: a FIFO queue; pop is served before the same-cycle push.
  logic [31:0] mq [$];
  logic [31:0] m_pair;
  int          m_i, m_q, m_ovf;
  logic        m_ov, m_irq, m_und;

  always @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      mq.delete();
      m_ov = 0; m_i = 0; m_q = 0; m_irq = 0; m_ovf = 0; m_und = 0;
    end else begin
      m_irq = (mq.size() >= THRESHOLD);
      if (bus.clear_flags) begin
        m_ovf = 0;
        m_und = 0;
      end
      m_ov = bus.pop;
      if (bus.pop) begin
        if (bus.rx_enable && mq.size() > 0) begin
          m_pair = mq.pop_front();
          m_i = int'($signed(m_pair[31:16]));
          m_q = int'($signed(m_pair[15:0]));
        end else begin
          m_i = 0; m_q = 0; m_und = 1;
        end
      end
      if (!bus.rx_enable) mq.delete();
      else if (bus.sample_valid) begin
        if (mq.size() < DEPTH) mq.push_back({bus.I, bus.Q});
        else if (m_ovf < 255) m_ovf++;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_in) begin
    if (!reset_in) begin
      chk("m.out_valid", int'(bus.out_valid), int'(m_ov));
      chk("m.I_out", int'(bus.I_out), m_i);
      chk("m.Q_out", int'(bus.Q_out), m_q);
      chk("m.level", int'(bus.level), mq.size());
      chk("m.irq", int'(bus.data_ready_irq), int'(m_irq));
      chk("m.overflow_cnt", int'(bus.overflow_cnt), m_ovf);
      chk("m.underrun", int'(bus.underrun), int'(m_und));
    end
  end

  task automatic cyc(input logic sv, input int i, input int q,
                     input logic p, input logic en, input logic cf);
    @(posedge clk_in);
    #2;
    bus.sample_valid = sv;
    bus.I            = 16'(i);
    bus.Q            = 16'(q);
    bus.pop          = p;
    bus.rx_enable    = en;
    bus.clear_flags  = cf;
  endtask

  task automatic look();
    cyc(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
    @(negedge clk_in);
  endtask

  initial begin
    bus.sample_valid = 0; bus.I = 0; bus.Q = 0;
    bus.pop = 0; bus.rx_enable = 1; bus.clear_flags = 0;
    #1;
    chk("rst.out_valid", int'(bus.out_valid), 0);
    chk("rst.level", int'(bus.level), 0);
    chk("rst.overflow_cnt", int'(bus.overflow_cnt), 0);
    repeat (3) @(posedge clk_in);
    #2 reset_in = 0;

    // Three pairs in, three out, one cycle after each pop
    for (int k = 1; k <= 3; k++) cyc(1'b1, k, -k, 1'b0, 1'b1, 1'b0);
    look();
    chk("t1.level3", int'(bus.level), 3);
    for (int k = 1; k <= 3; k++) begin
      cyc(1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
      look();
      chk("t1.valid", int'(bus.out_valid), 1);
      chk("t1.I", int'(bus.I_out), k);
      chk("t1.Q", int'(bus.Q_out), -k);
    end
    chk("t1.level0", int'(bus.level), 0);

    // Overfill, saturate the drop counter, clear coincident with a drop
    for (int k = 1; k <= 20; k++) cyc(1'b1, k, -k, 1'b0, 1'b1, 1'b0);
    look();
    chk("t2.level16", int'(bus.level), 16);
    chk("t2.ovf4", int'(bus.overflow_cnt), 4);
    chk("t2.irq", int'(bus.data_ready_irq), 1);
    for (int k = 0; k < 260; k++) cyc(1'b1, 500, 500, 1'b0, 1'b1, 1'b0);
    look();
    chk("t2.ovf_sat", int'(bus.overflow_cnt), 255);
    cyc(1'b1, 99, 99, 1'b0, 1'b1, 1'b1);
    look();
    chk("t2.ovf_clr_hit", int'(bus.overflow_cnt), 1);
    for (int k = 1; k <= 16; k++) begin
      cyc(1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
      look();
      chk("t2.I", int'(bus.I_out), k);
      chk("t2.Q", int'(bus.Q_out), -k);
    end
    chk("t2.irq_low", int'(bus.data_ready_irq), 0);

    // Empty pop then clear
    cyc(1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
    look();
    chk("t3.valid", int'(bus.out_valid), 1);
    chk("t3.I0", int'(bus.I_out), 0);
    chk("t3.Q0", int'(bus.Q_out), 0);
    chk("t3.underrun", int'(bus.underrun), 1);
    cyc(1'b0, 0, 0, 1'b0, 1'b1, 1'b1);
    look();
    chk("t3.underrun_clr", int'(bus.underrun), 0);

    // Full FIFO, push and pop together
    for (int k = 1; k <= 16; k++) cyc(1'b1, k, -k, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 100, -100, 1'b1, 1'b1, 1'b0);
    look();
    chk("t4.level16", int'(bus.level), 16);
    chk("t4.ovf0", int'(bus.overflow_cnt), 0);
    chk("t4.I_oldest", int'(bus.I_out), 1);
    chk("t4.Q_oldest", int'(bus.Q_out), -1);

    // rx_enable dropped for one cycle flushes the FIFO
    cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    look();
    chk("t5.level0", int'(bus.level), 0);
    look();
    chk("t5.irq0", int'(bus.data_ready_irq), 0);
    cyc(1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
    look();
    chk("t5.underrun", int'(bus.underrun), 1);
    chk("t5.I0", int'(bus.I_out), 0);

    // Reset in the middle of a pop with five pairs queued
    for (int k = 1; k <= 5; k++) cyc(1'b1, 10 + k, 20 + k, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
    #1;
    chk("t6.level5", int'(bus.level), 5);
    reset_in = 1'b1;
    #1;
    chk("t6.valid0", int'(bus.out_valid), 0);
    chk("t6.level0", int'(bus.level), 0);
    chk("t6.I0", int'(bus.I_out), 0);
    chk("t6.underrun0", int'(bus.underrun), 0);
    @(posedge clk_in);
    #1;
    chk("t6.valid_held0", int'(bus.out_valid), 0);
    #1;
    bus.pop  = 0;
    reset_in = 1'b0;

    // First edge after reset accepts traffic
    cyc(1'b1, 7, -7, 1'b0, 1'b1, 1'b0);
    look();
    chk("t7.level1", int'(bus.level), 1);
    cyc(1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
    look();
    chk("t7.I", int'(bus.I_out), 7);
    chk("t7.Q", int'(bus.Q_out), -7);
    look();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/rx_iq_scheduler.md
RX_IQ_SCHEDULER -- requirements
Module: rx_iq_scheduler

Interface
REQ-001 Parameter DEPTH, default 16: FIFO capacity in I/Q pairs (power of two).
REQ-002 Parameter THRESHOLD, default 8: fill level at which data_ready_irq asserts.
REQ-003 clk_in  input  1  sole clock; all logic on its rising edge.
REQ-004 reset_in  input  1  asynchronous, active-high reset.
REQ-005 sample_valid  input  1  one-cycle strobe: new DDC sample on I/Q.
REQ-006 I  input  16  signed DDC in-phase sample.
REQ-007 Q  input  16  signed DDC quadrature sample.
REQ-008 rx_enable  input  1  receive mode active; low = FIFO flushed and held empty.
REQ-009 pop  input  1  one-cycle request from the STM32 bus sequencer for the next pair.
REQ-010 clear_flags  input  1  one-cycle strobe clearing underrun and overflow_cnt.
REQ-011 I_out  output  16  signed registered in-phase pair output.
REQ-012 Q_out  output  16  signed registered quadrature pair output.
REQ-013 out_valid  output  1  one-cycle strobe: I_out/Q_out updated.
REQ-014 level  output  5  current fill, 0..DEPTH.
REQ-015 data_ready_irq  output  1  registered, high while level >= THRESHOLD.
REQ-016 overflow_cnt  output  8  saturating count of dropped samples.
REQ-017 underrun  output  1  sticky: pop seen while empty.

Function
REQ-018 Push: sample_valid=1 and rx_enable=1 SHALL store {I,Q} at write pointer; pointer advances mod DEPTH.
REQ-019 Full push (level=DEPTH, no same-cycle pop) SHALL drop the new sample, leave FIFO contents unchanged, increment overflow_cnt saturating at 255.
REQ-020 Pop with level>0 SHALL present the oldest pair on I_out/Q_out with out_valid=1 exactly one cycle after pop; read pointer advances mod DEPTH.
REQ-021 Pop with level=0 SHALL give out_valid=1 next cycle with I_out=Q_out=0 and set underrun; level stays 0.
REQ-022 Push and pop same cycle, level in 1..DEPTH: both SHALL succeed, level unchanged, no overflow counted.
REQ-023 Push and pop same cycle, level=0: no bypass; pop SHALL behave as REQ-021, push stored, level becomes 1.
REQ-024 I_out/Q_out SHALL hold their last value when out_valid=0.
REQ-025 data_ready_irq SHALL reflect level registered; it asserts the cycle after level reaches THRESHOLD and deasserts the cycle after it drops below.
REQ-026 rx_enable=0 SHALL reset both pointers and level to 0 on each clock while low; pushes ignored; pops behave as REQ-021.
REQ-027 clear_flags SHALL zero underrun and overflow_cnt; coincident with an overflow event, overflow_cnt SHALL become 1; coincident with an empty pop, underrun SHALL become 1.
REQ-028 Pointer width log2(DEPTH); level uses one extra bit; wrap-around SHALL not corrupt ordering.
REQ-029 Samples SHALL be stored bit-exact; no scaling, rounding or sign change.

Reset
REQ-030 reset_in=1 SHALL immediately force: pointers=0, level=0, I_out=0, Q_out=0, out_valid=0, data_ready_irq=0, overflow_cnt=0, underrun=0.
REQ-031 Reset asserted mid-transfer SHALL abort any pending out_valid; FIFO contents are don't-care after reset.
REQ-032 After reset deassertion, the first rising edge SHALL accept push/pop normally.

Verification
REQ-033 Push 3 pairs (I=1,2,3; Q=-1,-2,-3), pop 3 times -> out_valid pulses, outputs (1,-1),(2,-2),(3,-3) each one cycle after pop; level 3->0.
REQ-034 Push 20 pairs with rx_enable=1, no pops -> level=16, overflow_cnt=4, data_ready_irq=1; 16 pops return pairs 1..16 in order.
REQ-035 Pop on empty FIFO -> out_valid=1, I_out=Q_out=0, underrun=1; clear_flags -> underrun=0.
REQ-036 FIFO full, simultaneous push and pop -> level stays 16, overflow_cnt unchanged, oldest pair output.
REQ-037 Push 10 pairs, drop rx_enable one cycle -> level=0, data_ready_irq=0 next cycle; subsequent pop -> underrun.
REQ-038 Assert reset_in mid-pop with level=5 -> all outputs zero immediately, out_valid never pulses, level=0.
